// File: rtl/jtkicker_mainio.sv
// Main-CPU I/O block for Konami 6809 boards: addressable control latch, VBLANK IRQ,
// V16-divided NMI, frame watchdog and main-to-sound data latch.
module jtkicker_mainio #(
    parameter int LATCH_AW    = 3,
    parameter int IRQ_BIT     = 1,
    parameter int NMI_BIT     = 2,
    parameter int NMI_DIV     = 1,
    parameter int WDOG_FRAMES = 16,
    parameter int RST_LEN     = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cpu_cen,
    input  logic                     cpu_wr,
    input  logic [LATCH_AW-1:0]      cpu_addr,
    input  logic [7:0]               cpu_dout,
    input  logic                     lat_cs,
    input  logic                     wdog_cs,
    input  logic                     snd_cs,
    input  logic                     snd_rd,
    input  logic                     LVBL,
    input  logic                     V16,
    output logic [2**LATCH_AW-1:0]   lat_q,
    output logic                     irq_n,
    output logic                     nmi_n,
    output logic [7:0]               snd_latch,
    output logic                     snd_pend,
    output logic                     wdog_rst
);
    localparam int LATCH_N = 2**LATCH_AW;
    localparam int WW      = (WDOG_FRAMES > 1) ? $clog2(WDOG_FRAMES) : 1;
    localparam int RW      = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam int WLAST   = (WDOG_FRAMES > 0) ? WDOG_FRAMES - 1 : 0;
    localparam int RLAST   = (RST_LEN > 0) ? RST_LEN - 1 : 0;

    logic               lat_we, wdog_kick, snd_we;
    logic               lvbl_l, v16_l, vb_edge, v16_edge;
    logic               irq_pend, nmi_pend;
    logic [3:0]         nmi_cnt;
    logic [WW-1:0]      wd_cnt;
    logic [RW-1:0]      rst_cnt;
    logic [LATCH_N-1:0] lat_nx;

    assign lat_we    = cpu_cen & cpu_wr & lat_cs;
    assign wdog_kick = cpu_cen & cpu_wr & wdog_cs;
    assign snd_we    = cpu_cen & cpu_wr & snd_cs;
    assign vb_edge   = lvbl_l & ~LVBL;
    assign v16_edge  = ~v16_l & V16;

    // Enables are judged on the post-write latch value so a same-cycle clear wins
    always_comb begin
        lat_nx = lat_q;
        if (lat_we) lat_nx[cpu_addr] = cpu_dout[0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lat_q     <= '0;
            lvbl_l    <= 1'b1;
            v16_l     <= 1'b0;
            irq_pend  <= 1'b0;
            irq_n     <= 1'b1;
            nmi_pend  <= 1'b0;
            nmi_n     <= 1'b1;
            nmi_cnt   <= '0;
            wd_cnt    <= '0;
            rst_cnt   <= '0;
            wdog_rst  <= 1'b0;
            snd_latch <= '0;
            snd_pend  <= 1'b0;
        end else begin
            lat_q  <= lat_nx;
            lvbl_l <= LVBL;
            v16_l  <= V16;

            irq_pend <= lat_nx[IRQ_BIT] & (irq_pend | (vb_edge & lat_q[IRQ_BIT]));
            irq_n    <= ~irq_pend;

            if (!lat_nx[NMI_BIT]) begin
                nmi_cnt  <= '0;
                nmi_pend <= 1'b0;
            end else if (v16_edge && lat_q[NMI_BIT]) begin
                if (nmi_cnt == 4'(NMI_DIV - 1)) begin
                    nmi_cnt  <= '0;
                    nmi_pend <= 1'b1;
                end else begin
                    nmi_cnt <= nmi_cnt + 4'd1;
                end
            end
            nmi_n <= ~nmi_pend;

            // Frame counting is frozen while the reset pulse is out
            if (WDOG_FRAMES == 0) begin
                wd_cnt   <= '0;
                rst_cnt  <= '0;
                wdog_rst <= 1'b0;
            end else if (wdog_rst) begin
                if (rst_cnt == '0) wdog_rst <= 1'b0;
                else               rst_cnt  <= rst_cnt - RW'(1);
            end else if (wdog_kick) begin
                wd_cnt <= '0;
            end else if (vb_edge) begin
                if (wd_cnt == WW'(WLAST)) begin
                    wd_cnt   <= '0;
                    rst_cnt  <= RW'(RLAST);
                    wdog_rst <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + WW'(1);
                end
            end

            if (snd_we) begin
                snd_latch <= cpu_dout;
                snd_pend  <= 1'b1;
            end else if (snd_rd) begin
                snd_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jtkicker_mainio.sv
// Bench for jtkicker_mainio: event-level model checked every cycle plus directed literal checks.
module tb_jtkicker_mainio;
    localparam int AW = 3, IRQB = 1, NMIB = 2, NDIV = 3, WDF = 4, RLEN = 16;

    logic clk = 0, rstn = 0, cpu_cen = 0, cpu_wr = 0, lat_cs = 0, wdog_cs = 0, snd_cs = 0;
    logic snd_rd = 0, LVBL = 1, V16 = 0;
    logic [AW-1:0] cpu_addr = 0;
    logic [7:0] cpu_dout = 0, snd_latch;
    logic [7:0] lat_q;
    logic irq_n, nmi_n, snd_pend, wdog_rst;

    int checks = 0, failures = 0;

    jtkicker_mainio #(.LATCH_AW(AW), .IRQ_BIT(IRQB), .NMI_BIT(NMIB), .NMI_DIV(NDIV),
                      .WDOG_FRAMES(WDF), .RST_LEN(RLEN)) dut (
        .clk(clk), .rstn(rstn), .cpu_cen(cpu_cen), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .lat_cs(lat_cs), .wdog_cs(wdog_cs), .snd_cs(snd_cs),
        .snd_rd(snd_rd), .LVBL(LVBL), .V16(V16), .lat_q(lat_q), .irq_n(irq_n),
        .nmi_n(nmi_n), .snd_latch(snd_latch), .snd_pend(snd_pend), .wdog_rst(wdog_rst));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Event-level model: whole-number counters, pulse countdown, one-cycle output delay
    bit       m_valid = 0, m_lvbl = 1, m_v16 = 0, vb, ve;
    bit       m_irq_p, m_irq_n = 1, m_nmi_p, m_nmi_n = 1, m_pend;
    bit [7:0] m_lat, nl, old, m_latch;
    int       m_edges, m_frames, m_pulse;

    always @(posedge clk) begin
        if (!rstn) begin
            m_valid = 1; m_lat = 0; m_lvbl = 1; m_v16 = 0;
            m_irq_p = 0; m_irq_n = 1; m_nmi_p = 0; m_nmi_n = 1; m_edges = 0;
            m_frames = 0; m_pulse = 0; m_latch = 0; m_pend = 0;
        end else begin
            vb = m_lvbl && !LVBL;
            ve = !m_v16 && V16;
            m_lvbl = LVBL; m_v16 = V16;
            old = m_lat; nl = m_lat;
            if (cpu_cen && cpu_wr && lat_cs) nl[cpu_addr] = cpu_dout[0];
            m_irq_n = !m_irq_p;
            if (!nl[IRQB]) m_irq_p = 0;
            else if (vb && old[IRQB]) m_irq_p = 1;
            m_nmi_n = !m_nmi_p;
            if (!nl[NMIB]) begin m_nmi_p = 0; m_edges = 0; end
            else if (ve && old[NMIB]) begin
                m_edges++;
                if (m_edges % NDIV == 0) m_nmi_p = 1;
            end
            if (m_pulse > 0) m_pulse--;
            else if (cpu_cen && cpu_wr && wdog_cs) m_frames = 0;
            else if (vb) begin
                m_frames++;
                if (m_frames == WDF) begin m_frames = 0; m_pulse = RLEN; end
            end
            if (cpu_cen && cpu_wr && snd_cs) begin m_latch = cpu_dout; m_pend = 1; end
            else if (snd_rd) m_pend = 0;
            m_lat = nl;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("lat_q", 32'(lat_q), 32'(m_lat));
            check("irq_n", 32'(irq_n), 32'(m_irq_n));
            check("nmi_n", 32'(nmi_n), 32'(m_nmi_n));
            check("snd_latch", 32'(snd_latch), 32'(m_latch));
            check("snd_pend", 32'(snd_pend), 32'(m_pend));
            check("wdog_rst", 32'(wdog_rst), 32'(m_pulse > 0));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // sel: 0 control latch, 1 watchdog, 2 sound latch
    task automatic wr(input int sel, input int addr, input int data);
        cpu_cen = 1; cpu_wr = 1; cpu_addr = AW'(addr); cpu_dout = 8'(data);
        lat_cs = (sel == 0); wdog_cs = (sel == 1); snd_cs = (sel == 2);
        tick();
        cpu_cen = 0; cpu_wr = 0; lat_cs = 0; wdog_cs = 0; snd_cs = 0;
    endtask

    task automatic vfall();
        LVBL = 0; tick(); LVBL = 1; tick();
    endtask

    task automatic vrise();
        V16 = 1; tick(); V16 = 0; tick(); tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst lat_q", 32'(lat_q), 0);
        check("rst irq_n", 32'(irq_n), 1);
        check("rst nmi_n", 32'(nmi_n), 1);
        check("rst wdog", 32'(wdog_rst), 0);
        rstn = 1; tick();

        // IRQ enabled: two-clock latency, cleared by bit write
        wr(0, IRQB, 1);
        LVBL = 0; tick();
        check("irq 1clk", 32'(irq_n), 1);
        tick();
        check("irq 2clk", 32'(irq_n), 0);
        LVBL = 1;
        wr(0, IRQB, 0); tick();
        check("irq clr", 32'(irq_n), 1);

        // Edge while disabled is lost
        vfall();
        wr(0, IRQB, 1); repeat (3) tick();
        check("irq lost", 32'(irq_n), 1);
        wr(1, 0, 0);

        // NMI divide by 3, then restart after clear
        wr(0, NMIB, 1);
        vrise(); vrise();
        check("nmi 2 rises", 32'(nmi_n), 1);
        vrise();
        check("nmi 3 rises", 32'(nmi_n), 0);
        repeat (4) vrise();
        wr(0, NMIB, 0); tick();
        check("nmi clr", 32'(nmi_n), 1);
        wr(0, NMIB, 1);
        vrise(); vrise();
        check("nmi restart", 32'(nmi_n), 1);
        vrise();
        check("nmi restart 3", 32'(nmi_n), 0);

        // Watchdog expiry and pulse width
        wr(1, 0, 0);
        repeat (WDF - 1) vfall();
        check("wdog pre", 32'(wdog_rst), 0);
        LVBL = 0; tick();
        check("wdog fire", 32'(wdog_rst), 1);
        LVBL = 1; n = 1;
        while (wdog_rst && n < 100) begin
            tick();
            if (wdog_rst) n++;
        end
        check("wdog width", 32'(n), RLEN);

        // Regular kicks keep it quiet
        for (int k = 0; k < 4; k++) begin
            repeat (3) vfall();
            check("wdog kicked", 32'(wdog_rst), 0);
            wr(1, 0, 0);
        end

        // Sound latch
        wr(2, 0, 8'hA5);
        check("snd A5", 32'(snd_latch), 32'hA5);
        check("snd pend", 32'(snd_pend), 1);
        snd_rd = 1; wr(2, 0, 8'h3C); snd_rd = 0;
        check("snd 3C", 32'(snd_latch), 32'h3C);
        check("snd pend wins", 32'(snd_pend), 1);
        snd_rd = 1; tick(); snd_rd = 0;
        check("snd rd", 32'(snd_pend), 0);
        check("snd keep", 32'(snd_latch), 32'h3C);

        // Reset during pulse with IRQ pending
        wr(1, 0, 0);
        repeat (WDF) vfall();
        check("pre rst wdog", 32'(wdog_rst), 1);
        check("pre rst irq", 32'(irq_n), 0);
        rstn = 0; tick();
        check("mid rst lat_q", 32'(lat_q), 0);
        check("mid rst irq_n", 32'(irq_n), 1);
        check("mid rst nmi_n", 32'(nmi_n), 1);
        check("mid rst wdog", 32'(wdog_rst), 0);
        check("mid rst snd", 32'(snd_latch), 0);
        rstn = 1; repeat (RLEN + 2) tick();
        check("post rst wdog", 32'(wdog_rst), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
